kernel_cfg_arbiter: RTL and testbench

- Shares the single Gaussian kernel generator between NUM_REQ requesters, such as the blur stage and the pyramid/scale stage.
- Each requester asks for a (sigma, kernel_size) configuration. The block arbitrates round-robin and caches the configuration currently loaded in the generator.
- It restarts the generator only on a cache miss, holds the generator inputs stable while it runs, and grants exclusive use of the resulting kernel and sum until the owner releases it.

---
 rtl/kernel_cfg_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_kernel_cfg_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : kernel_cfg_arbiter
// Purpose  : Round-robin arbiter in front of the single Gaussian kernel
//            generator. Caches the (sigma, ksize) currently loaded in the
//            generator. Restarts it only on a miss and holds its inputs
//            steady while it runs. Grants exclusive use of the kernel and
//            its sum until the owner releases it.
// Ports    : clk, n_rst (async, active-low)
//            req/req_sigma/req_ksize/rel : requester side
//            grant, kernel_valid, kernel_sum, err, err_id, busy : status
//            gen_start/gen_sigma/gen_ksize -> generator
//            gen_done/gen_sum <- generator
// Revision : 1.0 - initial release
// ============================================================================
module kernel_cfg_arbiter #(
    parameter int    NUM_REQ        = 2,
    parameter int    MAX_KERNEL     = 7,
    parameter int    TIMEOUT_CYCLES = 64,
    localparam int   KW             = $clog2(MAX_KERNEL),
    localparam int   IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0][2:0]    req_sigma,
    input  logic [NUM_REQ-1:0][KW-1:0] req_ksize,
    input  logic [NUM_REQ-1:0]         rel,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       kernel_valid,
    output logic [31:0]                kernel_sum,
    output logic                       err,
    output logic [IDW-1:0]             err_id,
    output logic                       busy,
    output logic                       gen_start,
    output logic [2:0]                 gen_sigma,
    output logic [KW-1:0]              gen_ksize,
    input  logic                       gen_done,
    input  logic [31:0]                gen_sum
);

    localparam int            CW              = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [KW:0]   c_max_ksize     = (KW+1)'(MAX_KERNEL);
    localparam logic [CW-1:0] c_timeout_last  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_START    = 3'd2,
        S_WAIT_GEN = 3'd3,
        S_GRANTED  = 3'd4
    } state_t;

    state_t             r_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_win;
    logic [2:0]         r_lat_sigma;
    logic [KW-1:0]      r_lat_ksize;
    logic               r_loaded_valid;
    logic [2:0]         r_loaded_sigma;
    logic [KW-1:0]      r_loaded_ksize;
    logic [CW-1:0]      r_timer;

    logic               w_any;
    logic [IDW-1:0]     w_pick;
    logic [IDW:0]       w_scan;
    logic               w_illegal;
    logic               w_hit;
    logic [IDW-1:0]     w_next_ptr;
    logic [NUM_REQ-1:0] w_win_onehot;

    // Scan requesters starting at the round-robin pointer. The index is
    // kept one bit wider so the wrap can be done with a single subtract.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_scan = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_scan = {1'b0, r_rr_ptr} + (IDW+1)'(i);
            if (w_scan >= (IDW+1)'(NUM_REQ)) begin
                w_scan = w_scan - (IDW+1)'(NUM_REQ);
            end
            if (!w_any && req[w_scan[IDW-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_scan[IDW-1:0];
            end
        end
    end

    // Even sizes (including zero) have no centre tap.
    assign w_illegal = (r_lat_sigma == 3'd0) || !r_lat_ksize[0] ||
                       ({1'b0, r_lat_ksize} > c_max_ksize);

    assign w_hit = r_loaded_valid &&
                   (r_lat_sigma == r_loaded_sigma) &&
                   (r_lat_ksize == r_loaded_ksize);

    assign w_next_ptr   = (r_win == IDW'(NUM_REQ - 1)) ? '0 : r_win + IDW'(1);
    assign w_win_onehot = NUM_REQ'(1) << r_win;
    assign busy         = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state        <= S_IDLE;
            r_rr_ptr       <= '0;
            r_win          <= '0;
            r_lat_sigma    <= '0;
            r_lat_ksize    <= '0;
            r_loaded_valid <= 1'b0;
            r_loaded_sigma <= '0;
            r_loaded_ksize <= '0;
            r_timer        <= '0;
            grant          <= '0;
            kernel_valid   <= 1'b0;
            kernel_sum     <= '0;
            err            <= 1'b0;
            err_id         <= '0;
            gen_start      <= 1'b0;
            gen_sigma      <= '0;
            gen_ksize      <= '0;
        end else begin
            err       <= 1'b0;
            gen_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_win       <= w_pick;
                        r_lat_sigma <= req_sigma[w_pick];
                        r_lat_ksize <= req_ksize[w_pick];
                        r_state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_illegal) begin
                        err      <= 1'b1;
                        err_id   <= r_win;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= S_IDLE;
                    end else if (w_hit) begin
                        r_state  <= S_GRANTED;
                    end else begin
                        // Generator inputs change only here and then stay
                        // put until the next miss.
                        gen_sigma      <= r_lat_sigma;
                        gen_ksize      <= r_lat_ksize;
                        kernel_valid   <= 1'b0;
                        r_loaded_valid <= 1'b0;
                        gen_start      <= 1'b1;
                        r_state        <= S_START;
                    end
                end
                S_START: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_GEN;
                end
                S_WAIT_GEN: begin
                    if (gen_done) begin
                        kernel_sum     <= gen_sum;
                        r_loaded_sigma <= r_lat_sigma;
                        r_loaded_ksize <= r_lat_ksize;
                        r_loaded_valid <= 1'b1;
                        kernel_valid   <= 1'b1;
                        if (req[r_win]) begin
                            grant   <= w_win_onehot;
                            r_state <= S_GRANTED;
                        end else begin
                            // Requester withdrew: keep the freshly loaded
                            // kernel cached for whoever asks next.
                            r_rr_ptr <= w_next_ptr;
                            r_state  <= S_IDLE;
                        end
                    end else if (r_timer == c_timeout_last) begin
                        err            <= 1'b1;
                        err_id         <= r_win;
                        r_loaded_valid <= 1'b0;
                        kernel_valid   <= 1'b0;
                        r_rr_ptr       <= w_next_ptr;
                        r_state        <= S_IDLE;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + CW'(1);
                    end
                end
                S_GRANTED: begin
                    if (rel[r_win]) begin
                        grant    <= '0;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= S_IDLE;
                    end else begin
                        grant    <= w_win_onehot;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kernel_cfg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_kernel_cfg_arbiter
// Purpose  : Self-checking bench for kernel_cfg_arbiter with a behavioural
//            generator model and a cache/round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kernel_cfg_arbiter;

    localparam int NUM_REQ   = 2;
    localparam int KW        = 3;
    localparam int GEN_DELAY = 28;

    logic                       clk = 1'b0;
    logic                       n_rst = 1'b0;
    logic [NUM_REQ-1:0]         req = '0;
    logic [NUM_REQ-1:0][2:0]    req_sigma = '0;
    logic [NUM_REQ-1:0][KW-1:0] req_ksize = '0;
    logic [NUM_REQ-1:0]         rel = '0;
    logic [NUM_REQ-1:0]         grant;
    logic                       kernel_valid;
    logic [31:0]                kernel_sum;
    logic                       err;
    logic [0:0]                 err_id;
    logic                       busy;
    logic                       gen_start;
    logic [2:0]                 gen_sigma;
    logic [KW-1:0]              gen_ksize;
    logic                       gen_done;
    logic [31:0]                gen_sum;

    logic        model_done = 1'b0;
    logic [31:0] model_sum  = '0;
    logic        spur_done  = 1'b0;
    logic        gen_never  = 1'b0;
    logic [31:0] exp_sum    = '0;
    int          countdown  = 0;
    int          start_cnt  = 0;
    int          inv_viol   = 0;
    int          n_checks   = 0;
    int          n_pass     = 0;

    // Reference model state: what the generator holds and who is next.
    bit          m_lv = 1'b0;
    logic [2:0]  m_sigma = '0;
    logic [KW-1:0] m_ksize = '0;
    int          m_rr = 0;

    assign gen_done = model_done | spur_done;
    assign gen_sum  = spur_done ? ~exp_sum : model_sum;

    kernel_cfg_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .MAX_KERNEL     (7),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .req          (req),
        .req_sigma    (req_sigma),
        .req_ksize    (req_ksize),
        .rel          (rel),
        .grant        (grant),
        .kernel_valid (kernel_valid),
        .kernel_sum   (kernel_sum),
        .err          (err),
        .err_id       (err_id),
        .busy         (busy),
        .gen_start    (gen_start),
        .gen_sigma    (gen_sigma),
        .gen_ksize    (gen_ksize),
        .gen_done     (gen_done),
        .gen_sum      (gen_sum)
    );

    always #5 clk = ~clk;

    // Generator model: done pulse GEN_DELAY cycles after the start cycle.
    always @(negedge clk) begin
        model_done = 1'b0;
        if (!n_rst) begin
            countdown = 0;
        end else if (gen_start) begin
            start_cnt++;
            countdown = GEN_DELAY;
        end else if (countdown > 0) begin
            countdown--;
            if (countdown == 0 && !gen_never) begin
                model_sum  = $urandom;
                exp_sum    = model_sum;
                model_done = 1'b1;
            end
        end
        if ($countones(grant) > 1 || (grant != '0 && !kernel_valid)) inv_viol++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_event(input int max, output int cyc);
        cyc = 0;
        while (grant == '0 && !err && cyc < max) begin
            tick();
            cyc++;
        end
    endtask

    function automatic bit cfg_illegal(input logic [2:0] s, input logic [KW-1:0] k);
        return (s == 0) || (k % 2 == 0) || (k > 7);
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] mask);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mask[(m_rr + i) % NUM_REQ]) return (m_rr + i) % NUM_REQ;
        end
        return 0;
    endfunction

    function automatic bit is_miss(input logic [2:0] s, input logic [KW-1:0] k);
        return !(m_lv && s == m_sigma && k == m_ksize);
    endfunction

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({grant, kernel_valid, err, busy, gen_start} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000", {grant, kernel_valid, err, busy, gen_start});
        else n_pass++;
        n_checks++;
        if ({kernel_sum, gen_sigma, gen_ksize, err_id} !== 39'b0)
            $display("FAIL reset_data: got sum=%h sig=%0d k=%0d id=%0d want 0", kernel_sum, gen_sigma, gen_ksize, err_id);
        else n_pass++;
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_miss_then_hit();
        int cyc, s0;
        req_sigma[0] = 3'd2; req_ksize[0] = 3'd5;
        s0 = start_cnt; req = 2'b01;
        wait_event(100, cyc);
        n_checks++;
        if (grant !== 2'b01) $display("FAIL mth_grant: got %b want 01", grant); else n_pass++;
        n_checks++;
        if (cyc !== 31) $display("FAIL mth_miss_lat: got %0d want 31", cyc); else n_pass++;
        n_checks++;
        if (start_cnt - s0 !== 1) $display("FAIL mth_starts: got %0d want 1", start_cnt - s0); else n_pass++;
        n_checks++;
        if (kernel_sum !== exp_sum || !kernel_valid)
            $display("FAIL mth_sum: got %h/%b want %h/1", kernel_sum, kernel_valid, exp_sum);
        else n_pass++;
        m_lv = 1; m_sigma = 3'd2; m_ksize = 3'd5; m_rr = 1;
        tick(); tick();
        rel = 2'b01; req = 2'b00; tick(); rel = 2'b00;
        n_checks++;
        if (grant !== 2'b00) $display("FAIL mth_release: got %b want 00", grant); else n_pass++;
        tick();
        s0 = start_cnt; req = 2'b01;
        wait_event(100, cyc);
        n_checks++;
        if (cyc !== 3 || grant !== 2'b01) $display("FAIL mth_hit: got lat=%0d grant=%b want 3/01", cyc, grant); else n_pass++;
        n_checks++;
        if (start_cnt - s0 !== 0) $display("FAIL mth_hit_starts: got %0d want 0", start_cnt - s0); else n_pass++;
        m_rr = 1;
        rel = 2'b01; req = 2'b00; tick(); rel = 2'b00;
        tick();
    endtask

    task automatic test_round_robin();
        int cyc, s0, w;
        bit miss;
        logic [1:0] exp_g;
        req_sigma[0] = 3'd1; req_ksize[0] = 3'd3;
        req_sigma[1] = 3'd3; req_ksize[1] = 3'd3;
        req = 2'b11;
        for (int n = 0; n < 6; n++) begin
            if (n == 4) req_sigma[0] = 3'd3;
            w = rr_pick(req);
            miss = is_miss(req_sigma[w], req_ksize[w]);
            exp_g = 2'(1 << w);
            s0 = start_cnt;
            wait_event(100, cyc);
            n_checks++;
            if (grant !== exp_g) $display("FAIL rr_grant[%0d]: got %b want %b", n, grant, exp_g); else n_pass++;
            n_checks++;
            if (start_cnt - s0 !== int'(miss)) $display("FAIL rr_starts[%0d]: got %0d want %0d", n, start_cnt - s0, miss); else n_pass++;
            n_checks++;
            if (cyc !== (miss ? 31 : 3)) $display("FAIL rr_lat[%0d]: got %0d want %0d", n, cyc, miss ? 31 : 3); else n_pass++;
            m_lv = 1; m_sigma = req_sigma[w]; m_ksize = req_ksize[w]; m_rr = (w + 1) % NUM_REQ;
            repeat (3) tick();
            rel = exp_g; tick(); rel = 2'b00;
        end
        req = 2'b00;
        tick(); tick();
    endtask

    task automatic test_illegal();
        int cyc, s0;
        for (int n = 0; n < 2; n++) begin
            req_sigma[1] = (n == 0) ? 3'd2 : 3'd0;
            req_ksize[1] = (n == 0) ? 3'd4 : 3'd3;
            s0 = start_cnt; req = 2'b10;
            wait_event(20, cyc);
            req = 2'b00;
            n_checks++;
            if (err !== 1'b1 || err_id !== 1'b1) $display("FAIL ill_err[%0d]: got err=%b id=%0d want 1/1", n, err, err_id); else n_pass++;
            n_checks++;
            if (cyc !== 2 || grant !== 2'b00) $display("FAIL ill_lat[%0d]: got %0d grant=%b want 2/00", n, cyc, grant); else n_pass++;
            n_checks++;
            if (start_cnt - s0 !== 0) $display("FAIL ill_starts[%0d]: got %0d want 0", n, start_cnt - s0); else n_pass++;
            tick();
            n_checks++;
            if (busy !== 1'b0 || err !== 1'b0) $display("FAIL ill_idle[%0d]: got busy=%b err=%b want 0/0", n, busy, err); else n_pass++;
            m_rr = 0;
        end
    endtask

    task automatic test_timeout();
        int cyc, s0;
        req_sigma[0] = (m_lv && m_sigma == 3'd5 && m_ksize == 3'd7) ? 3'd6 : 3'd5;
        req_ksize[0] = 3'd7;
        gen_never = 1'b1;
        s0 = start_cnt; req = 2'b01;
        wait_event(200, cyc);
        req = 2'b00;
        n_checks++;
        if (err !== 1'b1 || err_id !== 1'b0) $display("FAIL to_err: got err=%b id=%0d want 1/0", err, err_id); else n_pass++;
        n_checks++;
        if (cyc !== 67) $display("FAIL to_lat: got %0d want 67", cyc); else n_pass++;
        n_checks++;
        if (kernel_valid !== 1'b0 || grant !== 2'b00) $display("FAIL to_kv: got kv=%b grant=%b want 0/00", kernel_valid, grant); else n_pass++;
        m_lv = 0; m_rr = 1;
        gen_never = 1'b0;
        tick(); tick();
        s0 = start_cnt; req = 2'b01;
        wait_event(100, cyc);
        n_checks++;
        if (start_cnt - s0 !== 1 || grant !== 2'b01) $display("FAIL to_retry: got starts=%0d grant=%b want 1/01", start_cnt - s0, grant); else n_pass++;
        n_checks++;
        if (kernel_sum !== exp_sum) $display("FAIL to_sum: got %h want %h", kernel_sum, exp_sum); else n_pass++;
        m_lv = 1; m_sigma = req_sigma[0]; m_ksize = req_ksize[0]; m_rr = 1;
        rel = 2'b01; req = 2'b00; tick(); rel = 2'b00;
        tick();
    endtask

    task automatic test_withdraw_spurious();
        int cyc, s0, k;
        bit seen;
        req_sigma[0] = (m_lv && m_sigma == 3'd7 && m_ksize == 3'd1) ? 3'd6 : 3'd7;
        req_ksize[0] = 3'd1;
        s0 = start_cnt; req = 2'b01;
        k = 0;
        while (start_cnt == s0 && k < 10) begin tick(); k++; end
        repeat (5) tick();
        req = 2'b00;
        seen = 1'b0;
        repeat (40) begin tick(); if (grant != 2'b00) seen = 1'b1; end
        n_checks++;
        if (seen !== 1'b0 || busy !== 1'b0) $display("FAIL wd_nogrant: got seen=%b busy=%b want 0/0", seen, busy); else n_pass++;
        n_checks++;
        if (kernel_valid !== 1'b1 || kernel_sum !== exp_sum) $display("FAIL wd_cache: got kv=%b sum=%h want 1/%h", kernel_valid, kernel_sum, exp_sum); else n_pass++;
        m_lv = 1; m_sigma = req_sigma[0]; m_ksize = req_ksize[0]; m_rr = 1;
        s0 = start_cnt; req = 2'b01;
        wait_event(100, cyc);
        n_checks++;
        if (cyc !== 3 || start_cnt - s0 !== 0) $display("FAIL wd_hit: got lat=%0d starts=%0d want 3/0", cyc, start_cnt - s0); else n_pass++;
        spur_done = 1'b1; rel = 2'b10; tick(); spur_done = 1'b0; rel = 2'b00;
        tick();
        n_checks++;
        if (grant !== 2'b01 || busy !== 1'b1) $display("FAIL spur_grant: got grant=%b busy=%b want 01/1", grant, busy); else n_pass++;
        n_checks++;
        if (kernel_sum !== exp_sum || start_cnt - s0 !== 0) $display("FAIL spur_sum: got %h starts=%0d want %h/0", kernel_sum, start_cnt - s0, exp_sum); else n_pass++;
        rel = 2'b01; req = 2'b00; tick(); rel = 2'b00;
        n_checks++;
        if (grant !== 2'b00) $display("FAIL spur_release: got %b want 00", grant); else n_pass++;
        m_rr = 1;
        tick();
    endtask

    task automatic test_random();
        int cyc, s0, w;
        bit bad, miss;
        logic [1:0] mask, exp_g;
        for (int n = 0; n < 16; n++) begin
            mask = 2'($urandom_range(1, 3));
            for (int r = 0; r < NUM_REQ; r++) begin
                req_sigma[r] = 3'($urandom_range(0, 3));
                req_ksize[r] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                           : 3'(2 * $urandom_range(0, 3) + 1);
            end
            w = rr_pick(mask);
            bad = cfg_illegal(req_sigma[w], req_ksize[w]);
            miss = is_miss(req_sigma[w], req_ksize[w]);
            exp_g = 2'(1 << w);
            s0 = start_cnt; req = mask;
            wait_event(100, cyc);
            if (bad) begin
                req = 2'b00;
                n_checks++;
                if (err !== 1'b1 || err_id !== 1'(w) || cyc !== 2)
                    $display("FAIL rnd_err[%0d]: got err=%b id=%0d lat=%0d want 1/%0d/2", n, err, err_id, cyc, w);
                else n_pass++;
                n_checks++;
                if (start_cnt - s0 !== 0) $display("FAIL rnd_err_starts[%0d]: got %0d want 0", n, start_cnt - s0); else n_pass++;
                m_rr = (w + 1) % NUM_REQ;
            end else begin
                n_checks++;
                if (grant !== exp_g || cyc !== (miss ? 31 : 3))
                    $display("FAIL rnd_grant[%0d]: got %b lat=%0d want %b/%0d", n, grant, cyc, exp_g, miss ? 31 : 3);
                else n_pass++;
                n_checks++;
                if (start_cnt - s0 !== int'(miss) || kernel_sum !== exp_sum)
                    $display("FAIL rnd_load[%0d]: got starts=%0d sum=%h want %0d/%h", n, start_cnt - s0, kernel_sum, miss, exp_sum);
                else n_pass++;
                m_lv = 1; m_sigma = req_sigma[w]; m_ksize = req_ksize[w]; m_rr = (w + 1) % NUM_REQ;
                rel = exp_g; req = 2'b00; tick(); rel = 2'b00;
            end
            tick();
            n_checks++;
            if (busy !== 1'b0 || grant !== 2'b00) $display("FAIL rnd_idle[%0d]: got busy=%b grant=%b want 0/00", n, busy, grant); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int cyc, s0, k;
        req_sigma[0] = 3'd1; req_ksize[0] = 3'd7;
        s0 = start_cnt; req = 2'b01;
        k = 0;
        while (start_cnt == s0 && k < 10) begin tick(); k++; end
        repeat (5) tick();
        n_rst = 1'b0;
        #2;
        n_checks++;
        if ({grant, kernel_valid, err, busy, gen_start} !== 6'b0)
            $display("FAIL rstmid_ctrl: got %b want 000000", {grant, kernel_valid, err, busy, gen_start});
        else n_pass++;
        n_checks++;
        if ({kernel_sum, gen_sigma, gen_ksize, err_id} !== 39'b0)
            $display("FAIL rstmid_data: got sum=%h sig=%0d k=%0d id=%0d want 0", kernel_sum, gen_sigma, gen_ksize, err_id);
        else n_pass++;
        req = 2'b00;
        tick();
        n_rst = 1'b1;
        m_lv = 0; m_rr = 0;
        tick();
        s0 = start_cnt; req = 2'b01;
        wait_event(100, cyc);
        n_checks++;
        if (start_cnt - s0 !== 1 || grant !== 2'b01 || cyc !== 31)
            $display("FAIL rstmid_miss: got starts=%0d grant=%b lat=%0d want 1/01/31", start_cnt - s0, grant, cyc);
        else n_pass++;
        rel = 2'b01; req = 2'b00; tick(); rel = 2'b00;
        tick();
    endtask

    task automatic test_invariants();
        n_checks++;
        if (inv_viol !== 0) $display("FAIL grant_invariant: got %0d violations want 0", inv_viol); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_miss_then_hit();
        test_round_robin();
        test_illegal();
        test_timeout();
        test_withdraw_spurious();
        test_random();
        test_reset_mid();
        test_invariants();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
